ddr4_odt_dly_ctrl: RTL and testbench
====================================

DDR4_ODT_DLY_CTRL -- requirements
Module: ddr4_odt_dly_ctrl

Interface
REQ-001 Parameter TAP_MAX, default 127: highest legal delay-line tap index; tap_cnt saturates here.
REQ-002 Parameter GAP_CYCLES, default 4, legal range 1..15: idle cycles after every MOVE or LOAD pulse, for delay-line settling.
REQ-003 FAB_CLK  in  1  single clock for all logic.
REQ-004 ARST  in  1  asynchronous, active-high reset.
REQ-005 req_valid  in  1  request present.
REQ-006 req_ready  out  1  controller can accept a request.
REQ-007 req_op  in  2  operation code: 00 = increment, 01 = decrement, 10 = load (return to tap 0), 11 = no-op.
REQ-008 req_taps  in  8  number of single-tap moves requested (increment and decrement only).
REQ-009 done  out  1  one-cycle pulse when a request completes.
REQ-010 err_oor  out  1  sticky error flag: the request was aborted because the delay line went out of range or tap_cnt would have saturated.
REQ-011 tap_cnt  out  8  tracked current tap position.
REQ-012 DELAY_LINE_MOVE  out  1  move strobe to the IOD delay line.
REQ-013 DELAY_LINE_DIRECTION  out  1  move direction to the IOD delay line: 1 = increment, 0 = decrement.
REQ-014 DELAY_LINE_LOAD  out  1  load strobe to the IOD delay line.
REQ-015 DELAY_LINE_OUT_OF_RANGE  in  1  out-of-range status from the IOD delay line.

Function
REQ-016 The state machine SHALL have the states IDLE, MOVE, LOAD, GAP and DONE.
REQ-017 req_ready SHALL be 1 only in IDLE; a request is accepted on the cycle where req_valid and req_ready are both 1 (cycle t).
REQ-018 On acceptance, the block SHALL register req_op and req_taps into a remaining-moves counter, and SHALL clear err_oor.
REQ-019 On acceptance, DELAY_LINE_DIRECTION SHALL be registered from req_op, as 1 for op 00 and 0 otherwise.
REQ-020 DELAY_LINE_DIRECTION SHALL be held stable until the block returns to IDLE.
REQ-021 Op 00 or 01 with a nonzero remaining count SHALL go from IDLE to MOVE.
REQ-022 MOVE SHALL last one cycle, with DELAY_LINE_MOVE = 1 in that cycle, and SHALL then go to GAP.
REQ-023 On leaving MOVE, the remaining count SHALL decrement and tap_cnt SHALL step by +1 or -1 according to direction.
REQ-024 GAP SHALL last exactly GAP_CYCLES cycles.
REQ-025 At the end of GAP, the block SHALL go to MOVE if the remaining count is nonzero, and to DONE otherwise.
REQ-026 Op 00 or 01 with req_taps = 0, and op 11, SHALL go from IDLE straight to DONE; done then pulses at t+1 and no strobe is issued.
REQ-027 Op 10 SHALL go from IDLE to LOAD, which asserts DELAY_LINE_LOAD for one cycle and sets tap_cnt to 0.
REQ-028 After LOAD, the block SHALL go to GAP and then to DONE.
REQ-029 Latency: for a move request, the first MOVE pulse SHALL occur at t+1 and done SHALL occur at t + N*(GAP_CYCLES+1) + 1, where N = req_taps.
REQ-030 Latency: for a load request, done SHALL occur at t + GAP_CYCLES + 2.
REQ-031 DONE SHALL last one cycle, with done = 1, and SHALL then return to IDLE; done is never asserted in any other state.
REQ-032 If DELAY_LINE_OUT_OF_RANGE is 1 in any GAP cycle of a move request, the block SHALL set err_oor, skip the remaining moves and go to DONE on the next cycle.
REQ-033 If a pending move would take tap_cnt above TAP_MAX or below 0, the block SHALL issue no strobe, set err_oor and go to DONE; tap_cnt is never wrapped.
REQ-034 err_oor SHALL stay set until the next accepted request.
REQ-035 DELAY_LINE_MOVE and DELAY_LINE_LOAD SHALL never both be 1 in the same cycle.
REQ-036 DELAY_LINE_MOVE and DELAY_LINE_LOAD SHALL always be driven directly from registers.
REQ-037 req_valid is ignored outside IDLE; the controller does not queue requests.

Reset
REQ-038 ARST = 1 SHALL asynchronously force state to IDLE and set req_ready = 1 while reset is released.
REQ-039 ARST = 1 SHALL asynchronously drive done, err_oor, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION and DELAY_LINE_LOAD to 0.
REQ-040 ARST = 1 SHALL asynchronously clear tap_cnt, the remaining-moves counter and the gap counter to 0.
REQ-041 Reset asserted mid-operation SHALL abort the operation with no done pulse.
REQ-042 After reset is released, the first clock edge SHALL be able to accept a request.

Structure
REQ-043 The state enumeration, the op-code constants and the GAP counter width SHALL be defined in the shared package ddr4_phy_ctrl_pkg.
REQ-044 The block SHALL contain one sub-module, ddr4_dly_gap_timer, a loadable down-counter that flags expiry; all other logic is flat.

Verification
REQ-045 Scenario 1: after reset, op 00 with req_taps = 3 and GAP_CYCLES = 4 -> MOVE pulses at t+1, t+6 and t+11, DIRECTION = 1 throughout, done at t+16, tap_cnt = 3.
REQ-046 Scenario 2: with tap_cnt = 3, op 01 with req_taps = 5 -> 3 MOVE pulses, err_oor = 1, done pulsed, tap_cnt = 0.
REQ-047 Scenario 3: op 00 with req_taps = 10, and DELAY_LINE_OUT_OF_RANGE = 1 during the 2nd GAP -> exactly 2 MOVE pulses, err_oor = 1, tap_cnt = 2.
REQ-048 Scenario 4: op 10 at tap_cnt = 50 -> single LOAD pulse at t+1, done at t+6, tap_cnt = 0, err_oor = 0.
REQ-049 Scenario 5: op 00 with req_taps = 0, then op 11 -> done at t+1 for each, and no strobes.
REQ-050 Scenario 6: ARST asserted during the 2nd GAP of a 5-tap move -> all outputs 0 immediately, no done pulse, req_ready = 1 after release.

Source files
------------

// File: rtl/ddr4_phy_ctrl_pkg.sv
// Shared types and constants for the DDR4 PHY delay-line control blocks.
package ddr4_phy_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MOVE,
    ST_LOAD,
    ST_GAP,
    ST_DONE
  } dly_state_e;

  typedef enum logic [1:0] {
    OP_INC  = 2'b00,
    OP_DEC  = 2'b01,
    OP_LOAD = 2'b10,
    OP_NOP  = 2'b11
  } dly_op_e;

  localparam int unsigned GAP_CNT_W = 4;

endpackage

// File: rtl/ddr4_dly_gap_timer.sv
// Loadable down-counter that flags expiry; times the settling gap after each strobe.
module ddr4_dly_gap_timer
  import ddr4_phy_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [GAP_CNT_W-1:0] load_val,
  input  logic                 en,
  output logic                 expired
);

  logic [GAP_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/ddr4_odt_dly_ctrl.sv
// IOD delay-line tap controller: issues spaced MOVE/LOAD strobes and tracks the tap position.
module ddr4_odt_dly_ctrl
  import ddr4_phy_ctrl_pkg::*;
#(
  parameter int unsigned TAP_MAX    = 127,
  parameter int unsigned GAP_CYCLES = 4
) (
  input  logic       FAB_CLK,
  input  logic       ARST,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  input  logic [7:0] req_taps,
  output logic       done,
  output logic       err_oor,
  output logic [7:0] tap_cnt,
  output logic       DELAY_LINE_MOVE,
  output logic       DELAY_LINE_DIRECTION,
  output logic       DELAY_LINE_LOAD,
  input  logic       DELAY_LINE_OUT_OF_RANGE
);

  localparam logic [7:0]           TAP_MAX_L = 8'(TAP_MAX);
  localparam logic [GAP_CNT_W-1:0] GAP_LOAD  = GAP_CNT_W'(GAP_CYCLES - 1);

  dly_state_e state_q, state_d;
  dly_op_e    op_q, op_d, in_op;
  logic [7:0] rem_q, rem_d;
  logic [7:0] tap_q, tap_d;
  logic       dir_q, dir_d;
  logic       err_q, err_d;
  logic       move_q, move_d;
  logic       load_q, load_d;
  logic       done_q, done_d;

  logic accept, acc_blocked, run_blocked, oor_abort, gap_end, gap_expired;

  assign in_op       = dly_op_e'(req_op);
  assign accept      = req_valid && (state_q == ST_IDLE);
  assign acc_blocked = (in_op == OP_INC) ? (tap_q == TAP_MAX_L) : (tap_q == '0);
  assign run_blocked = dir_q ? (tap_q == TAP_MAX_L) : (tap_q == '0);
  assign oor_abort   = (state_q == ST_GAP) && (op_q != OP_LOAD) && DELAY_LINE_OUT_OF_RANGE;
  assign gap_end     = (state_q == ST_GAP) && gap_expired;

  ddr4_dly_gap_timer u_gap_timer (
    .clk      (FAB_CLK),
    .rst      (ARST),
    .load     ((state_q == ST_MOVE) || (state_q == ST_LOAD)),
    .load_val (GAP_LOAD),
    .en       (state_q == ST_GAP),
    .expired  (gap_expired)
  );

  always_ff @(posedge FAB_CLK or posedge ARST) begin
    if (ARST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (in_op)
            OP_INC, OP_DEC: state_d = ((req_taps == '0) || acc_blocked) ? ST_DONE : ST_MOVE;
            OP_LOAD:        state_d = ST_LOAD;
            default:        state_d = ST_DONE;
          endcase
        end
      end
      ST_MOVE: state_d = ST_GAP;
      ST_LOAD: state_d = ST_GAP;
      ST_GAP: begin
        if (oor_abort) begin
          state_d = ST_DONE;
        end else if (gap_expired) begin
          state_d = ((rem_q == '0) || run_blocked) ? ST_DONE : ST_MOVE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobes and done are decoded from the next state so they leave the flops aligned with the state.
  always_comb begin
    move_d = (state_d == ST_MOVE);
    load_d = (state_d == ST_LOAD);
    done_d = (state_d == ST_DONE);
  end

  always_comb begin
    op_d  = op_q;
    rem_d = rem_q;
    tap_d = tap_q;
    dir_d = dir_q;
    err_d = err_q;
    if (accept) begin
      op_d  = in_op;
      rem_d = req_taps;
      dir_d = (in_op == OP_INC);
      err_d = ((in_op == OP_INC) || (in_op == OP_DEC)) && (req_taps != '0) && acc_blocked;
    end
    if (state_q == ST_MOVE) begin
      rem_d = rem_q - 1'b1;
      tap_d = dir_q ? (tap_q + 1'b1) : (tap_q - 1'b1);
    end
    if (state_q == ST_LOAD) begin
      tap_d = '0;
    end
    if (oor_abort || (gap_end && (rem_q != '0) && run_blocked)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge FAB_CLK or posedge ARST) begin
    if (ARST) begin
      op_q   <= OP_NOP;
      rem_q  <= '0;
      tap_q  <= '0;
      dir_q  <= 1'b0;
      err_q  <= 1'b0;
      move_q <= 1'b0;
      load_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      op_q   <= op_d;
      rem_q  <= rem_d;
      tap_q  <= tap_d;
      dir_q  <= dir_d;
      err_q  <= err_d;
      move_q <= move_d;
      load_q <= load_d;
      done_q <= done_d;
    end
  end

  assign req_ready            = (state_q == ST_IDLE);
  assign done                 = done_q;
  assign err_oor              = err_q;
  assign tap_cnt              = tap_q;
  assign DELAY_LINE_MOVE      = move_q;
  assign DELAY_LINE_DIRECTION = dir_q;
  assign DELAY_LINE_LOAD      = load_q;

endmodule

// File: tb/tb_ddr4_odt_dly_ctrl.sv
// Scoreboard bench for ddr4_odt_dly_ctrl: expected completions queued at issue, checked on done.
module tb_ddr4_odt_dly_ctrl;

  logic       FAB_CLK = 1'b0;
  logic       ARST    = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_op = 2'b11;
  logic [7:0] req_taps = '0;
  logic       done, err_oor;
  logic [7:0] tap_cnt;
  logic       mv, dir, ld;
  logic       oor = 1'b0;

  ddr4_odt_dly_ctrl #(.TAP_MAX(127), .GAP_CYCLES(4)) dut (
    .FAB_CLK                 (FAB_CLK),
    .ARST                    (ARST),
    .req_valid               (req_valid),
    .req_ready               (req_ready),
    .req_op                  (req_op),
    .req_taps                (req_taps),
    .done                    (done),
    .err_oor                 (err_oor),
    .tap_cnt                 (tap_cnt),
    .DELAY_LINE_MOVE         (mv),
    .DELAY_LINE_DIRECTION    (dir),
    .DELAY_LINE_LOAD         (ld),
    .DELAY_LINE_OUT_OF_RANGE (oor)
  );

  always #5 FAB_CLK = ~FAB_CLK;

  int cyc = 0;
  always @(posedge FAB_CLK) cyc <= cyc + 1;

  typedef struct {
    int done_cyc;
    int tap;
    int err;
    int moves;
    int loads;
    int first;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  logic cur_dir = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: counts strobes between completions and checks each completion against the queue.
  int mv_cnt = 0, ld_cnt = 0, first_cyc = -1;
  always @(negedge FAB_CLK) begin
    if (ARST) begin
      mv_cnt = 0; ld_cnt = 0; first_cyc = -1;
    end else begin
      if (mv || ld) begin
        chk("strobe_exclusive", int'(mv && ld), 0);
        if (first_cyc < 0) first_cyc = cyc;
      end
      if (mv) begin
        mv_cnt++;
        chk("move_direction", int'(dir), int'(cur_dir));
      end
      if (ld) ld_cnt++;
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("done_cycle", cyc, e.done_cyc);
          chk("tap_cnt", int'(tap_cnt), e.tap);
          chk("err_oor", int'(err_oor), e.err);
          chk("move_pulses", mv_cnt, e.moves);
          chk("load_pulses", ld_cnt, e.loads);
          chk("first_strobe_cycle", first_cyc, e.first);
        end
        mv_cnt = 0; ld_cnt = 0; first_cyc = -1;
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [7:0] taps, input int lat,
                       input int etap, input int eerr, input int emv, input int eld,
                       input bit push);
    exp_t e;
    int   t;
    @(negedge FAB_CLK);
    chk("ready_before_issue", int'(req_ready), 1);
    req_valid = 1'b1;
    req_op    = op;
    req_taps  = taps;
    cur_dir   = (op == 2'b00);
    t         = cyc;
    if (push) begin
      e.done_cyc = t + lat;
      e.tap      = etap;
      e.err      = eerr;
      e.moves    = emv;
      e.loads    = eld;
      e.first    = (emv + eld > 0) ? t + 1 : -1;
      sb.push_back(e);
    end
    @(posedge FAB_CLK);
    #1 req_valid = 1'b0;
    req_op = 2'b11;
  endtask

  task automatic drain;
    int i;
    for (i = 0; i < 2000; i++) begin
      if (sb.size() == 0) break;
      @(negedge FAB_CLK);
    end
    if (sb.size() != 0) begin
      chk("done_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge FAB_CLK);
    #1;
    chk("rst_ready", int'(req_ready), 1);
    chk("rst_tap", int'(tap_cnt), 0);
    chk("rst_outputs", int'({done, err_oor, mv, dir, ld}), 0);
    ARST = 1'b0;

    // inc 3: moves t+1,t+6,t+11, done t+16
    issue(2'b00, 8'd3, 16, 3, 0, 3, 0, 1'b1);
    drain();
    // dec 5 from 3: floor hit after 3 moves
    issue(2'b01, 8'd5, 16, 0, 1, 3, 0, 1'b1);
    drain();
    // inc 10 with out-of-range during 2nd gap (cycle t+7)
    issue(2'b00, 8'd10, 8, 2, 1, 2, 0, 1'b1);
    repeat (7) @(negedge FAB_CLK);
    oor = 1'b1;
    @(negedge FAB_CLK);
    oor = 1'b0;
    drain();
    // inc 48 to reach tap 50
    issue(2'b00, 8'd48, 241, 50, 0, 48, 0, 1'b1);
    drain();
    // load from tap 50
    issue(2'b10, 8'd0, 6, 0, 0, 0, 1, 1'b1);
    drain();
    // zero-tap inc and no-op
    issue(2'b00, 8'd0, 1, 0, 0, 0, 0, 1'b1);
    drain();
    issue(2'b11, 8'd7, 1, 0, 0, 0, 0, 1'b1);
    drain();
    // dec at tap 0: blocked at acceptance
    issue(2'b01, 8'd1, 1, 0, 1, 0, 0, 1'b1);
    drain();

    // reset during 2nd gap of a 5-tap move; no completion expected
    issue(2'b00, 8'd5, 0, 0, 0, 0, 0, 1'b0);
    repeat (7) @(negedge FAB_CLK);
    chk("pre_reset_tap", int'(tap_cnt), 2);
    ARST = 1'b1;
    #1;
    chk("arst_outputs", int'({done, err_oor, mv, dir, ld}), 0);
    chk("arst_tap", int'(tap_cnt), 0);
    chk("arst_ready", int'(req_ready), 1);
    @(posedge FAB_CLK);
    #1 ARST = 1'b0;
    chk("post_reset_ready", int'(req_ready), 1);
    issue(2'b00, 8'd1, 6, 1, 0, 1, 0, 1'b1);
    drain();
    repeat (5) @(negedge FAB_CLK);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
